// File: rtl/seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_pkg
//   Shared types and sizes for the repeated-addition sequential multiplier
//   (product = A * B, built from regA, a regB down-counter and an accumulator).
//
//   Contents:
//     WIDTH_A, WIDTH_B, WIDTH_P : operand A, operand B / iteration counter, product widths
//     MAX_ITER                  : accumulate cycles allowed before the watchdog fires
//     seq_mul_state_t           : controller state encoding (IDLE, LOAD, ACC)
// -----------------------------------------------------------------------------
package seq_mul_pkg;

  localparam int WIDTH_A  = 3;
  localparam int WIDTH_B  = 3;
  localparam int WIDTH_P  = 6;

  // Must stay <= 2**WIDTH_B-1 so the iteration counter can represent it.
  localparam int MAX_ITER = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACC  = 2'd2
  } seq_mul_state_t;

endpackage

// File: rtl/seq_mul_if.sv
// -----------------------------------------------------------------------------
// seq_mul_if
//   Bundles the requester handshake and the datapath control/status lines of
//   the sequential multiplier controller.
//
//   Handshake: the requester raises start; it is sampled only while the
//   controller is idle (busy=0), so starts issued while busy are dropped, not
//   queued. busy is high for the whole operation. Exactly one of done / err
//   pulses for one cycle at the end of each operation that is not cut short
//   by reset; done marks the single cycle in which the accumulator holds A*B.
//
//   Signals:
//     start     requester -> ctrl  operation request
//     eqz       datapath  -> ctrl  regB output == 0 (combinational)
//     loadA     ctrl -> datapath   load operand A into regA
//     loadB     ctrl -> datapath   load operand B into regB
//     decB      ctrl -> datapath   1: product += A, regB -= 1; 0: accumulator clears
//     busy      ctrl -> requester  operation in progress (LOAD or ACC)
//     done      ctrl -> requester  1-cycle pulse, product valid
//     err       ctrl -> requester  1-cycle pulse, watchdog abort
//     state_dbg ctrl -> observer   current FSM state
//     iter_dbg  ctrl -> observer   current accumulate-iteration count
//
//   Modports: master = controller side, slave = requester/datapath side.
// -----------------------------------------------------------------------------
interface seq_mul_if #(
  parameter int WIDTH_B = seq_mul_pkg::WIDTH_B
);
  import seq_mul_pkg::*;

  logic                 start;
  logic                 eqz;
  logic                 loadA;
  logic                 loadB;
  logic                 decB;
  logic                 busy;
  logic                 done;
  logic                 err;
  seq_mul_state_t       state_dbg;
  logic [WIDTH_B-1:0]   iter_dbg;

  modport master (
    input  start,
    input  eqz,
    output loadA,
    output loadB,
    output decB,
    output busy,
    output done,
    output err,
    output state_dbg,
    output iter_dbg
  );

  modport slave (
    output start,
    output eqz,
    input  loadA,
    input  loadB,
    input  decB,
    input  busy,
    input  done,
    input  err,
    input  state_dbg,
    input  iter_dbg
  );

endinterface

// File: rtl/seq_mul_iter_cnt.sv
// -----------------------------------------------------------------------------
// seq_mul_iter_cnt
//   Iteration counter for the multiplier watchdog. Clears on clr, counts up on
//   en, and holds at MAX_ITER so it can never wrap.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst    in   synchronous, active-high reset (count <= 0)
//     clr    in   synchronous clear (count <= 0), dominant over en
//     en     in   count enable
//     count  out  current count, WIDTH_B bits
//     tc     out  terminal count: count == MAX_ITER (combinational from count)
// -----------------------------------------------------------------------------
module seq_mul_iter_cnt #(
  parameter int WIDTH_B  = 3,
  parameter int MAX_ITER = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [WIDTH_B-1:0] count,
  output logic               tc
);

  localparam logic [WIDTH_B-1:0] LIMIT = WIDTH_B'(MAX_ITER);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      // Saturating: the controller never enables past LIMIT, but holding here
      // keeps the counter safe if it is reused elsewhere.
      count <= count + WIDTH_B'(1);
    end
  end

  assign tc = (count == LIMIT);

endmodule

// File: rtl/seq_mul_controller.sv
// -----------------------------------------------------------------------------
// seq_mul_controller
//   Control unit of the repeated-addition sequential multiplier. Drives
//   loadA / loadB / decB into regA, the regB down-counter and the accumulator,
//   runs the start / done handshake toward the requester, and aborts with an
//   err pulse if regB fails to reach zero within MAX_ITER accumulate cycles.
//
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   synchronous, active-high reset
//     bus   seq_mul_if.master  (start, eqz in; loadA, loadB, decB, busy,
//                               done, err, state_dbg, iter_dbg out)
//
//   Timing: start seen at edge n -> LOAD in cycle n+1 -> ACC from n+2 ->
//   done in cycle n+2+B (B = operand loaded into regB).
// -----------------------------------------------------------------------------
module seq_mul_controller #(
  parameter int WIDTH_B  = seq_mul_pkg::WIDTH_B,
  parameter int MAX_ITER = seq_mul_pkg::MAX_ITER
) (
  input  logic      clk,
  input  logic      rst,
  seq_mul_if.master bus
);
  import seq_mul_pkg::*;

  seq_mul_state_t      state;
  logic [WIDTH_B-1:0]  iter;
  logic                iter_tc;

  logic                load_a;
  logic                load_b;
  logic                dec_b;
  logic                busy;
  logic                done;
  logic                err;

  // ---------------------------------------------------------------------------
  // Watchdog iteration counter: cleared in LOAD, advanced once per accumulate.
  // ---------------------------------------------------------------------------
  seq_mul_iter_cnt #(
    .WIDTH_B  (WIDTH_B),
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == LOAD),
    .en    (dec_b),
    .count (iter),
    .tc    (iter_tc)
  );

  // ---------------------------------------------------------------------------
  // State register. In ACC, eqz is tested before the watchdog, so an operand
  // of exactly MAX_ITER still completes with done rather than err.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          state <= ACC;
        end
        ACC: begin
          if (bus.eqz || iter_tc) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the registered state plus eqz. done has to appear in
  // the same cycle eqz rises (that is the only cycle the product is valid),
  // so these outputs are a decode rather than a further register stage.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_a = 1'b0;
    load_b = 1'b0;
    dec_b  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (state)
      LOAD: begin
        load_a = 1'b1;
        load_b = 1'b1;
        busy   = 1'b1;
      end
      ACC: begin
        busy = 1'b1;
        if (bus.eqz) begin
          done = 1'b1;
        end else if (iter_tc) begin
          err = 1'b1;
        end else begin
          dec_b = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.loadA     = load_a;
  assign bus.loadB     = load_b;
  assign bus.decB      = dec_b;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.state_dbg = state;
  assign bus.iter_dbg  = iter;

endmodule

// File: tb/tb_seq_mul_controller.sv
module tb_seq_mul_controller;
  import seq_mul_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_mul_if bus ();

  seq_mul_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------------------------------
  // Datapath models: regA, regB down-counter, accumulator
  // ---------------------------------------------------------------------------
  logic [2:0] a_in  = '0;
  logic [2:0] b_in  = '0;
  bit         stuck = 1'b0;   // forces eqz low to emulate a stuck datapath
  logic [2:0] reg_a = '0;
  logic [2:0] reg_b = '0;
  logic [5:0] acc   = '0;

  always @(posedge clk) begin
    if (bus.loadA) reg_a <= a_in;
    if (bus.loadB) reg_b <= b_in;
    else if (bus.decB) reg_b <= reg_b - 3'd1;
    if (bus.decB) acc <= acc + {3'b000, reg_a};
    else acc <= '0;
  end

  assign bus.eqz = stuck ? 1'b0 : (reg_b == 3'd0);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table and reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    bit         stuck;
    int         exp_decb;   // number of accumulate cycles
    int         exp_end;    // cycle (LOAD = 1) of the done/err pulse
    bit         exp_done;
    bit         exp_err;
    logic [5:0] exp_prod;
  } vec_t;

  // Operation-level model: B accumulations then done, unless the datapath
  // never reports zero, in which case MAX_ITER accumulations then err.
  function automatic vec_t make_vec(input logic [2:0] a, input logic [2:0] b, input bit st);
    vec_t v;
    v.a        = a;
    v.b        = b;
    v.stuck    = st;
    v.exp_decb = st ? MAX_ITER : int'(b);
    v.exp_end  = 2 + v.exp_decb;
    v.exp_done = !st;
    v.exp_err  = st;
    v.exp_prod = 6'(a) * 6'(b);
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one start pulse, observe until done/err (bounded), then one more cycle
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input bit st,
                        output int load_cyc, output int decb_cnt, output int end_cyc,
                        output bit got_done, output bit got_err, output logic [5:0] prod,
                        output bit bad, output bit busy_after);
    a_in  = a;
    b_in  = b;
    stuck = st;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    load_cyc = -1; decb_cnt = 0; end_cyc = -1;
    got_done = 1'b0; got_err = 1'b0; prod = '0; bad = 1'b0;
    for (int c = 1; c <= 40 && end_cyc < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.loadA && bus.loadB && load_cyc < 0) load_cyc = c;
      if ((bus.loadA || bus.loadB) && bus.decB) bad = 1'b1;
      if (bus.done && bus.err) bad = 1'b1;
      if (!bus.busy) bad = 1'b1;
      if (bus.decB) decb_cnt++;
      if (bus.done) begin got_done = 1'b1; prod = acc; end
      if (bus.err) got_err = 1'b1;
      if (bus.done || bus.err) end_cyc = c;
    end
    @(negedge clk);
    busy_after = bus.busy;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int load_cyc, decb_cnt, end_cyc;
    bit got_done, got_err, bad, busy_after;
    logic [5:0] prod;
    if (v.exp_done) exp_q.push_back(v.exp_prod);
    run_op(v.a, v.b, v.stuck, load_cyc, decb_cnt, end_cyc, got_done, got_err, prod, bad, busy_after);
    check({tag, " load_cycle"}, load_cyc, 1);
    check({tag, " decb_cycles"}, decb_cnt, v.exp_decb);
    check({tag, " end_cycle"}, end_cyc, v.exp_end);
    check({tag, " done"}, int'(got_done), int'(v.exp_done));
    check({tag, " err"}, int'(got_err), int'(v.exp_err));
    check({tag, " protocol"}, int'(bad), 0);
    check({tag, " busy_after"}, int'(busy_after), 0);
    if (got_done && exp_q.size() > 0) check({tag, " product"}, int'(prod), int'(exp_q.pop_front()));
  endtask

  function automatic int outs();
    return int'({bus.loadA, bus.loadB, bus.decB, bus.busy, bus.done, bus.err});
  endfunction

  // ---------------------------------------------------------------------------
  // Global time limit
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finished");
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t vecs[16];

  initial begin
    bus.start = 1'b0;
    rst = 1'b1;

    // Reset state: all outputs 0 while rst held.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_outs%0d", i), outs(), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", outs(), 0);

    // Directed table entries (scenarios 1-4 plus a few extras), then random ones.
    vecs[0] = '{3'd3, 3'd2, 1'b0, 2, 4, 1'b1, 1'b0, 6'd6};
    vecs[1] = '{3'd5, 3'd0, 1'b0, 0, 2, 1'b1, 1'b0, 6'd0};
    vecs[2] = '{3'd7, 3'd7, 1'b0, 7, 9, 1'b1, 1'b0, 6'd49};
    vecs[3] = '{3'd4, 3'd3, 1'b1, 7, 9, 1'b0, 1'b1, 6'd0};
    vecs[4] = '{3'd1, 3'd1, 1'b0, 1, 3, 1'b1, 1'b0, 6'd1};
    vecs[5] = '{3'd0, 3'd5, 1'b0, 5, 7, 1'b1, 1'b0, 6'd0};
    for (int i = 6; i < 16; i++) begin
      vecs[i] = make_vec(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                         ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 16; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end
    stuck = 1'b0;

    // Reset in the second ACC cycle: outputs drop, no pulse, next op clean.
    begin
      int pulses;
      pulses = 0;
      a_in = 3'd6; b_in = 3'd5;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;          // cycle 1: LOAD
      pulses += int'(bus.done) + int'(bus.err);
      @(negedge clk);                            // cycle 2: ACC #1
      pulses += int'(bus.done) + int'(bus.err);
      @(negedge clk);                            // cycle 3: ACC #2
      check("rst_mid_decb_before", int'(bus.decB), 1);
      pulses += int'(bus.done) + int'(bus.err);
      rst = 1'b1;
      @(negedge clk);                            // cycle 4: reset applied
      check("rst_mid_outs", outs(), 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        pulses += int'(bus.done) + int'(bus.err) + int'(bus.busy);
      end
      check("rst_mid_no_pulse", pulses, 0);
      apply_vec(make_vec(3'd6, 3'd2, 1'b0), "after_rst");
    end

    // Start held high for 10 cycles with B=1: back-to-back operations.
    begin
      int load_mask, done_mask, exp_load, exp_done, prod_bad, s;
      load_mask = 0; done_mask = 0; prod_bad = 0;
      a_in = 3'd3; b_in = 3'd1;
      @(negedge clk); bus.start = 1'b1;          // cycle 0
      for (int c = 1; c <= 14; c++) begin
        @(negedge clk);
        if (c == 10) bus.start = 1'b0;
        if (bus.loadA) load_mask |= (1 << c);
        if (bus.done) begin
          done_mask |= (1 << c);
          if (acc != 6'd3) prod_bad++;
        end
      end
      // Each op spans LOAD + B accumulates + done cycle + one IDLE cycle in
      // which the held start is sampled again.
      exp_load = 0; exp_done = 0; s = 1;
      while (s <= 14) begin
        exp_load |= (1 << s);
        if (s + 2 <= 14) exp_done |= (1 << (s + 2));
        if (s + 3 <= 9) s += 4;
        else break;
      end
      check("held_start_loads", load_mask, exp_load);
      check("held_start_dones", done_mask, exp_done);
      check("held_start_product", prod_bad, 0);
    end

    // Start pulse while busy is ignored.
    begin
      int load_mask, done_mask, prod;
      load_mask = 0; done_mask = 0; prod = -1;
      @(negedge clk);
      a_in = 3'd2; b_in = 3'd3;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        if (c > 1) @(negedge clk);
        if (c == 3) bus.start = 1'b1;
        if (c == 4) bus.start = 1'b0;
        if (bus.loadA) load_mask |= (1 << c);
        if (bus.done) begin done_mask |= (1 << c); prod = int'(acc); end
      end
      check("busy_start_loads", load_mask, 1 << 1);
      check("busy_start_dones", done_mask, 1 << 5);
      check("busy_start_product", prod, 6);
    end

    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
